// File: rtl/wb_stage.sv
// wb_stage: write-back pipeline stage of the MIPS core.
// Holds the instruction leaving MEM, stalls loads until the data-memory read
// response arrives, aligns/merges load data (LB/LBU/LH/LHU/LW/LWL/LWR) and
// drives the register-file write port, the ID forwarding view and the
// NSCSCC debug trace.
// Ports:
//   clk, reset (sync, active-low)
//   ms_*            instruction handed over by MEM (valid/pc/we/dest/ld_op/result/rt)
//   ws_allow_in     WB can accept a new instruction this cycle
//   flush           exception/eret flush, kills the WB instruction
//   dm_rvalid/rdata in-order data-memory read response
//   rf_we/waddr/wdata       register-file write port
//   ws_fwd_*                forwarding view for ID
//   debug_wb_*              debug trace
module wb_stage #(
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          ms_to_ws_valid,
    output logic          ws_allow_in,
    input  logic [31:0]   ms_pc,
    input  logic          ms_gpr_we,
    input  logic [4:0]    ms_dest,
    input  logic [2:0]    ms_ld_op,
    input  logic [DW-1:0] ms_result,
    input  logic [DW-1:0] ms_rt_value,
    input  logic          flush,
    input  logic          dm_rvalid,
    input  logic [DW-1:0] dm_rdata,
    output logic          rf_we,
    output logic [4:0]    rf_waddr,
    output logic [DW-1:0] rf_wdata,
    output logic          ws_fwd_valid,
    output logic          ws_fwd_ready,
    output logic [4:0]    ws_fwd_dest,
    output logic [DW-1:0] ws_fwd_data,
    output logic [31:0]   debug_wb_pc,
    output logic [3:0]    debug_wb_rf_wen,
    output logic [4:0]    debug_wb_rf_wnum,
    output logic [DW-1:0] debug_wb_rf_wdata
);

    typedef enum logic [2:0] {
        LD_NONE = 3'b000,
        LD_W    = 3'b001,
        LD_B    = 3'b010,
        LD_BU   = 3'b011,
        LD_H    = 3'b100,
        LD_HU   = 3'b101,
        LD_WL   = 3'b110,
        LD_WR   = 3'b111
    } ld_op_e;

    logic          ws_valid;
    logic          drop_pending;
    logic [31:0]   ws_pc;
    logic          ws_gpr_we;
    logic [4:0]    ws_dest;
    ld_op_e        ws_ld_op;
    logic [DW-1:0] ws_result;
    logic [DW-1:0] ws_rt_value;

    logic          is_load;
    logic          load_rvalid;
    logic          ws_ready_go;
    logic          ws_waiting;
    logic [1:0]    a;
    logic [7:0]    ld_byte;
    logic [15:0]   ld_half;
    logic [DW-1:0] wdata;

    assign is_load     = (ws_ld_op != LD_NONE);
    // A response arriving while drop_pending is set belongs to a killed load.
    assign load_rvalid = dm_rvalid & ~drop_pending;
    assign ws_ready_go = ~is_load | load_rvalid;
    assign ws_allow_in = ~ws_valid | ws_ready_go;
    assign ws_waiting  = ws_valid & is_load & ~load_rvalid;

    always_ff @(posedge clk) begin
        if (!reset) begin
            ws_valid     <= 1'b0;
            drop_pending <= 1'b0;
            ws_pc        <= '0;
            ws_gpr_we    <= 1'b0;
            ws_dest      <= '0;
            ws_ld_op     <= LD_NONE;
            ws_result    <= '0;
            ws_rt_value  <= '0;
        end else begin
            if (flush) begin
                ws_valid <= 1'b0;
            end else if (ws_allow_in) begin
                ws_valid <= ms_to_ws_valid;
            end

            if (ms_to_ws_valid && ws_allow_in && !flush) begin
                ws_pc       <= ms_pc;
                ws_gpr_we   <= ms_gpr_we;
                ws_dest     <= ms_dest;
                ws_ld_op    <= ld_op_e'(ms_ld_op);
                ws_result   <= ms_result;
                ws_rt_value <= ms_rt_value;
            end

            // A load killed before its response leaves one response in flight.
            if (flush && ws_waiting) begin
                drop_pending <= 1'b1;
            end else if (dm_rvalid && drop_pending) begin
                drop_pending <= 1'b0;
            end
        end
    end

    assign a = ws_result[1:0];

    always_comb begin
        ld_byte = dm_rdata[7:0];
        case (a)
            2'd0: ld_byte = dm_rdata[7:0];
            2'd1: ld_byte = dm_rdata[15:8];
            2'd2: ld_byte = dm_rdata[23:16];
            2'd3: ld_byte = dm_rdata[31:24];
            default: ld_byte = dm_rdata[7:0];
        endcase
        ld_half = a[1] ? dm_rdata[31:16] : dm_rdata[15:0];
    end

    always_comb begin
        wdata = ws_result;
        case (ws_ld_op)
            LD_W:  wdata = dm_rdata;
            LD_B:  wdata = {{24{ld_byte[7]}}, ld_byte};
            LD_BU: wdata = {24'd0, ld_byte};
            LD_H:  wdata = {{16{ld_half[15]}}, ld_half};
            LD_HU: wdata = {16'd0, ld_half};
            LD_WL: begin
                case (a)
                    2'd0: wdata = {dm_rdata[7:0],  ws_rt_value[23:0]};
                    2'd1: wdata = {dm_rdata[15:0], ws_rt_value[15:0]};
                    2'd2: wdata = {dm_rdata[23:0], ws_rt_value[7:0]};
                    default: wdata = dm_rdata;
                endcase
            end
            LD_WR: begin
                case (a)
                    2'd0: wdata = dm_rdata;
                    2'd1: wdata = {ws_rt_value[31:24], dm_rdata[31:8]};
                    2'd2: wdata = {ws_rt_value[31:16], dm_rdata[31:16]};
                    default: wdata = {ws_rt_value[31:8], dm_rdata[31:24]};
                endcase
            end
            default: wdata = ws_result;
        endcase
    end

    // A non-load completes its write before a flush edge takes effect; a load
    // whose response lands in a flush cycle is consumed without writing.
    assign rf_we    = ws_valid & ws_ready_go & ws_gpr_we & ~(flush & is_load);
    assign rf_waddr = ws_dest;
    assign rf_wdata = wdata;

    // Gated by ws_valid so an empty stage does not advertise ready data.
    assign ws_fwd_valid = ws_valid & ws_gpr_we;
    assign ws_fwd_ready = ws_valid & ws_ready_go;
    assign ws_fwd_dest  = ws_dest;
    assign ws_fwd_data  = wdata;

    assign debug_wb_pc       = ws_pc;
    assign debug_wb_rf_wen   = {4{rf_we}};
    assign debug_wb_rf_wnum  = ws_dest;
    assign debug_wb_rf_wdata = wdata;

endmodule
